fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the IF/ID latch.
- Owns the PC and issues single-outstanding requests to the instruction cache.
- Buffers one returned instruction in a skid register and presents it to IF/ID with a valid/stall handshake.
- Applies branch/jump redirects and halt from later stages.

Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- imemREN  output  1  instruction read request to icache.
- imemaddr  output  32  fetch address; equals PC while imemREN=1.
- ihit  input  1  icache hit; imemload valid in the same cycle.
- imemload  input  32  instruction word from icache.
- stall  input  1  IF/ID not accepting (hazard unit, or IF/ID writeEN=0).
- redirect  input  1  taken branch/jump/JR resolved downstream.
- redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 0).
- halt  input  1  HALT decoded downstream; stop fetching.
- valid_out  output  1  output buffer holds an instruction; drives IF/ID writeEN.
- instr_out  output  32  buffered instruction; drives IF/ID instr_in.
- pcplus4_out  output  32  PC+4 of buffered instruction; drives IF/ID pcplus4_in.
- flush_out  output  1  drives IF/ID flush; equals redirect, combinational.
- halted  output  1  high in HALTED state.

Behaviour:
- State machine: RUN and HALTED. Reset -> RUN. RUN -> HALTED when halt=1. HALTED is sticky until RST.
- Reset values: pc=PC_INIT, valid_out=0, instr_out=0, pcplus4_out=0, halted=0.
- Acceptance: accept = valid_out & ~stall. The buffered entry leaves on any cycle where accept=1.
- Request:
  - imemREN = RUN & ~redirect & ~halt & (~valid_out | accept).
  - imemaddr = pc, held stable until ihit.
  - At most one request outstanding; no request issues while the buffer is full and not draining.
- Fill: on imemREN & ihit, at the next edge:
  - instr_out <= imemload; pcplus4_out <= pc+4; valid_out <= 1; pc <= pc+4.
  - Latency is 1 cycle from ihit to valid_out.
- Drain without fill (accept=1, no ihit): valid_out <= 0.
- Simultaneous accept and fill: the buffer is replaced by the new instruction and valid_out stays 1. This gives back-to-back throughput of 1 instr/cycle when ihit is continuous.
- Stall with a full buffer: hold all outputs and pc unchanged; imemREN=0.
- Redirect (RUN, halt=0):
  - pc <= {redirect_pc[31:2],2'b00}; valid_out <= 0.
  - Any ihit in the same cycle is discarded.
  - flush_out=1 for that cycle.
  - Redirect overrides stall.
- Halt: next edge -> HALTED, valid_out <= 0, pc frozen. halt has priority over redirect when both are asserted in the same cycle.
- HALTED: imemREN=0; redirect, ihit and stall are ignored; flush_out still follows redirect.
- PC arithmetic: 32-bit modulo. 32'hFFFFFFFC + 4 = 32'h00000000; no error is flagged.
- RST mid-request (ihit pending): the request is abandoned; imemREN=0 in the reset cycle; state restored to reset values.
- ihit while imemREN=0: ignored.

Test Plan:
- Reset with PC_INIT=0, ihit tied to 1, stall=0, imemload=addr-derived -> imemaddr sequence 0,4,8,C; valid_out high from cycle 2; pcplus4_out sequence 4,8,C,10; one instr/cycle.
- ihit delayed 3 cycles on address 0x10 -> imemaddr held at 0x10 with imemREN=1 for all 3 cycles; valid_out rises exactly 1 cycle after ihit; pcplus4_out=0x14.
- stall=1 for 4 cycles with valid_out=1 -> instr_out and pcplus4_out frozen; imemREN=0; pc unchanged. On release, the buffered instruction is accepted, then the next fetch proceeds at the old pc.
- redirect=1, redirect_pc=0x43, coincident with ihit -> fetched word dropped; valid_out=0 next cycle; flush_out=1; next imemaddr=0x40.
- halt=1 and redirect=1 in the same cycle -> halted=1, imemREN stays 0 for 10 cycles, pc not updated to redirect_pc; RST restores pc=PC_INIT and halted=0.
- Redirect to 0xFFFFFFFC with ihit continuous -> pcplus4_out=0x00000000; next imemaddr=0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction-fetch stage: PC, icache request, one-entry output buffer
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pcplus4_out,
  output logic        flush_out,
  output logic        halted
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        accept;
  logic        fill;

  assign accept          = valid_out & ~stall;
  assign fill            = imemREN & ihit;
  assign pc_plus4        = pc + 32'd4;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign imemaddr        = pc;
  assign flush_out       = redirect;

  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state == RUN && halt) next_state = HALTED;
  end

  // Request is squashed during reset so an in-flight fetch is abandoned.
  always_comb begin
    imemREN = 1'b0;
    halted  = (state == HALTED);
    if (!RST && state == RUN && !redirect && !halt && (!valid_out || accept))
      imemREN = 1'b1;
  end

  // Priority: halt, then redirect (which drops any coincident ihit), then fill, then drain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc          <= PC_INIT;
      valid_out   <= 1'b0;
      instr_out   <= 32'h0;
      pcplus4_out <= 32'h0;
    end else if (state == RUN) begin
      if (halt) begin
        valid_out <= 1'b0;
      end else if (redirect) begin
        pc        <= redirect_target;
        valid_out <= 1'b0;
      end else if (fill) begin
        instr_out   <= imemload;
        pcplus4_out <= pc_plus4;
        pc          <= pc_plus4;
        valid_out   <= 1'b1;
      end else if (accept) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - fetch_unit bench: directed scenarios plus random traffic against a behavioural model
module tb_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h00000000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pcplus4_out;
  logic        flush_out;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc, m_instr, m_pcp4;
  logic        m_valid, m_halted;

  fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .valid_out(valid_out),
    .instr_out(instr_out), .pcplus4_out(pcplus4_out), .flush_out(flush_out),
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ren();
    return !RST && !m_halted && !redirect && !halt && (!m_valid || !stall);
  endfunction

  task automatic model_reset();
    m_pc = PC_INIT; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic drive(input logic rst_i, input logic ihit_i, input logic stall_i,
                       input logic redir_i, input logic [31:0] rpc_i, input logic halt_i);
    RST = rst_i; ihit = ihit_i; stall = stall_i; redirect = redir_i;
    redirect_pc = rpc_i; halt = halt_i;
    imemload = $urandom;
    #1;
  endtask

  // Compare every output against the model, then advance model across one clock edge.
  task automatic tick();
    logic ren;
    ren = model_ren();
    check("imemREN", {31'b0, imemREN}, {31'b0, ren});
    if (ren) check("imemaddr", imemaddr, m_pc);
    check("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
    check("instr_out", instr_out, m_instr);
    check("pcplus4_out", pcplus4_out, m_pcp4);
    check("flush_out", {31'b0, flush_out}, {31'b0, redirect});
    check("halted", {31'b0, halted}, {31'b0, m_halted});
    @(posedge CLK);
    if (RST) model_reset();
    else if (!m_halted) begin
      if (halt) begin
        m_halted = 1'b1; m_valid = 1'b0;
      end else if (redirect) begin
        m_pc = {redirect_pc[31:2], 2'b00}; m_valid = 1'b0;
      end else if (ren && ihit) begin
        m_instr = imemload; m_pcp4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
      end else if (m_valid && !stall) begin
        m_valid = 1'b0;
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    halt = 1'b0; imemload = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    model_reset();

    // Reset state
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_imemREN", {31'b0, imemREN}, 32'h0);
    check("rst_valid", {31'b0, valid_out}, 32'h0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_pcp4", pcplus4_out, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    tick();

    // Continuous ihit: one instruction per cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("seq_addr", imemaddr, 32'(4 * k));
      check("seq_ren", {31'b0, imemREN}, 32'h1);
      tick();
      check("seq_pcp4", pcplus4_out, 32'(4 * (k + 1)));
      check("seq_valid", {31'b0, valid_out}, 32'h1);
    end

    // ihit delayed three cycles on 0x10
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("wait_addr", imemaddr, 32'h10);
      check("wait_ren", {31'b0, imemREN}, 32'h1);
      tick();
    end
    check("wait_valid_low", {31'b0, valid_out}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check("late_valid", {31'b0, valid_out}, 32'h1);
    check("late_pcp4", pcplus4_out, 32'h14);

    // Stall with full buffer
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      check("stall_ren", {31'b0, imemREN}, 32'h0);
      check("stall_pcp4", pcplus4_out, 32'h14);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("release_addr", imemaddr, 32'h14);
    tick();
    check("release_pcp4", pcplus4_out, 32'h18);

    // Redirect coincident with ihit
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h43, 1'b0);
    check("redir_flush", {31'b0, flush_out}, 32'h1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("redir_valid", {31'b0, valid_out}, 32'h0);
    check("redir_addr", imemaddr, 32'h40);
    tick();

    // Halt wins over redirect; sticky until reset
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'b0);
      check("halt_halted", {31'b0, halted}, 32'h1);
      check("halt_ren", {31'b0, imemREN}, 32'h0);
      check("halt_pc", imemaddr, 32'h44);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("unhalt_halted", {31'b0, halted}, 32'h0);
    check("unhalt_pc", imemaddr, PC_INIT);
    tick();

    // PC wraparound
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap_addr0", imemaddr, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap_pcp4", pcplus4_out, 32'h0);
    check("wrap_addr1", imemaddr, 32'h0);
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 59) == 0, 1'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 399) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
